sng_frame4: RTL and testbench
=============================

# sng_frame4

Four-channel stochastic number generator and frame accumulator that sits directly downstream of the 16-bit four-output LFSR. Each cycle it compares the four 4-bit random words against four latched 4-bit probability values to emit four stochastic bitstreams for the network datapath. Over a frame of FRAME_LEN cycles it also counts the ones on each channel and publishes the counts with a one-cycle DONE pulse. The counts give binary readback and self-check of the generated streams.

## Interface
Parameters:
- FRAME_LEN, 256: bitstream length per frame in cycles; must be ≥ 2.
- CW, 9: count width; must satisfy 2^CW > FRAME_LEN.

Ports:
- TRIG, in, 1: clock; the same trigger that shifts the LFSR. All state changes on the rising edge.
- RESET, in, 1: one clock; reset is synchronous and active-high.
- START, in, 1: frame request, sampled on the TRIG edge.
- P0, P1, P2, P3, in, 4 each: channel probabilities, where value v means probability v/16.
- RND0, RND1, RND2, RND3, in, 4 each: random words from the LFSR outputs OUT0..OUT3.
- BIT0, BIT1, BIT2, BIT3, out, 1 each: registered stochastic bits.
- BUSY, out, 1: high while a frame is running.
- DONE, out, 1: one-cycle pulse; CNT0..CNT3 change only on the edge that raises DONE.
- CNT0, CNT1, CNT2, CNT3, out, CW each: ones-count of the last completed frame.

## Operation
- FSM states:
  - IDLE: the reset state.
  - RUN: frame in progress.
  - FIN: frame complete.
- Internal registers:
  - PL0..PL3 (4 bits each): latched probabilities.
  - ACC0..ACC3 (CW bits each): accumulators.
  - FCNT: frame counter, clog2(FRAME_LEN) bits.
- IDLE or FIN with START=1:
  - PLi <= Pi, ACCi <= 0, FCNT <= 0, state becomes RUN.
- IDLE or FIN with START=0:
  - Go to or stay in IDLE.
- RUN, every edge:
  - ci = (RNDi < PLi), as an unsigned 4-bit compare.
  - BITi <= ci and ACCi <= ACCi + ci.
  - FCNT <= FCNT + 1.
- RUN exit: on the edge where FCNT == FRAME_LEN-1:
  - state becomes FIN.
  - CNTi <= ACCi + ci, so the final sample is included.
- START while in RUN is ignored. PLi stays frozen for the whole frame; changes on Pi mid-frame have no effect.
- Outside RUN, each edge clears BITi to 0. This happens on the FIN edge and on IDLE edges.
- Combinational outputs: BUSY = (state == RUN), DONE = (state == FIN).
- Range rules:
  - Pi = 0 gives all-zero bitstreams.
  - Pi = 15 gives BITi = 0 only when RNDi = 15.
  - Pi is never 16, so CNTi ≤ FRAME_LEN and never overflows CW.
- CNTi holds its value between frames. It is not cleared by START.
- Reset, which wins over START in any state:
  - State returns to IDLE.
  - BITi, CNTi, ACCi, PLi and FCNT are all set to 0.
  - BUSY and DONE are 0.
  - A frame in progress is aborted with no DONE pulse.

## Timing
- Edge e0: START is sampled high in IDLE or FIN. BUSY goes high after e0.
- Edges e1..eN, with N = FRAME_LEN: RUN samples. BITi after edge ek reflects RNDi as sampled at ek.
- Edge eN: BUSY drops, DONE rises, and CNTi is valid from then on.
- Edge eN+1: DONE drops and BITi returns to 0.
- START to DONE latency is FRAME_LEN+1 edges.
- Back-to-back frames: START held high during the FIN cycle makes e(N+1) the e0 of the next frame. Frame period is then FRAME_LEN+1 cycles.
- No combinational path from RND or P inputs to any output.

## Test plan
All benches use FRAME_LEN=16 and CW=5.
- Exhaustive compare: RND0..3 driven by a counter 0,1,…,15 starting at e1; P = {0, 5, 10, 15}; pulse START → DONE 17 edges after START, CNT = {0, 5, 10, 15}, and BIT1 = 1 exactly at samples 0..4.
- Mid-frame changes: P0 changed from 8 to 3 at e5 and START re-asserted at e7 → CNT0 = 8, BUSY stays high, only one DONE pulse.
- Reset mid-frame: RESET asserted at e9 → next cycle has BUSY=0, DONE=0, CNT=0, BIT=0; no DONE pulse follows; a later START runs a clean frame with correct counts.
- Back-to-back frames: START held high continuously with P0 = 15 and the RND counter running → DONE pulses every 17 cycles, each CNT0 = 15, and BUSY is low only in the FIN cycles.
- Live LFSR: connected to the LFSR with seed 16'hACE1, P = {4, 8, 12, 15}, FRAME_LEN=256 rebuild → each CNTi within ±10% of 16·Pi; every BITi is 0 in IDLE.

Source files
------------

// File: rtl/sng_frame4.sv
// sng_frame4: four-channel stochastic number generator with per-frame ones counters.
// Compares LFSR words against latched probabilities and publishes frame counts with a DONE pulse.
`default_nettype none

module sng_frame4 #(
  parameter int FRAME_LEN = 256,
  parameter int CW        = 9
) (
  input  logic          TRIG,
  input  logic          RESET,
  input  logic          START,
  input  logic [3:0]    P0,
  input  logic [3:0]    P1,
  input  logic [3:0]    P2,
  input  logic [3:0]    P3,
  input  logic [3:0]    RND0,
  input  logic [3:0]    RND1,
  input  logic [3:0]    RND2,
  input  logic [3:0]    RND3,
  output logic          BIT0,
  output logic          BIT1,
  output logic          BIT2,
  output logic          BIT3,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] CNT0,
  output logic [CW-1:0] CNT1,
  output logic [CW-1:0] CNT2,
  output logic [CW-1:0] CNT3
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] LAST = FW'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state;
  logic [FW-1:0] fcnt;
  logic [3:0]    pl   [4];
  logic [CW-1:0] acc  [4];
  logic [CW-1:0] cnt  [4];
  logic [3:0]    bits;
  logic [3:0]    rnd  [4];
  logic [3:0]    prob [4];
  logic [3:0]    cmp;

  always_comb begin
    rnd[0]  = RND0;
    rnd[1]  = RND1;
    rnd[2]  = RND2;
    rnd[3]  = RND3;
    prob[0] = P0;
    prob[1] = P1;
    prob[2] = P2;
    prob[3] = P3;
    cmp     = '0;
    for (int i = 0; i < 4; i++) begin
      cmp[i] = (rnd[i] < pl[i]);
    end
  end

  always_ff @(posedge TRIG) begin
    if (RESET) begin
      state <= S_IDLE;
      fcnt  <= '0;
      bits  <= '0;
      for (int i = 0; i < 4; i++) begin
        pl[i]  <= '0;
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        S_RUN: begin
          bits <= cmp;
          fcnt <= fcnt + 1'b1;
          for (int i = 0; i < 4; i++) begin
            acc[i] <= acc[i] + CW'(cmp[i]);
          end
          // The last sample is folded straight into the published count.
          if (fcnt == LAST) begin
            state <= S_FIN;
            for (int i = 0; i < 4; i++) begin
              cnt[i] <= acc[i] + CW'(cmp[i]);
            end
          end
        end
        S_IDLE, S_FIN: begin
          bits <= '0;
          if (START) begin
            state <= S_RUN;
            fcnt  <= '0;
            for (int i = 0; i < 4; i++) begin
              pl[i]  <= prob[i];
              acc[i] <= '0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          bits  <= '0;
        end
      endcase
    end
  end

  assign BIT0 = bits[0];
  assign BIT1 = bits[1];
  assign BIT2 = bits[2];
  assign BIT3 = bits[3];
  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_FIN);
  assign CNT0 = cnt[0];
  assign CNT1 = cnt[1];
  assign CNT2 = cnt[2];
  assign CNT3 = cnt[3];

endmodule

`default_nettype wire

// File: tb/tb_sng_frame4.sv
// tb_sng_frame4: directed plus randomized checks of sng_frame4 against a frame-level reference model.
`default_nettype none

module tb_sng_frame4;

  localparam int FL = 16;
  localparam int CW = 5;

  logic          TRIG = 1'b0;
  logic          RESET, START;
  logic [3:0]    P0, P1, P2, P3, RND0, RND1, RND2, RND3;
  logic          BIT0, BIT1, BIT2, BIT3, BUSY, DONE;
  logic [CW-1:0] CNT0, CNT1, CNT2, CNT3;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame running flag, sample position, latched probabilities.
  bit m_run, m_fin;
  int m_pos;
  int m_pl[4], m_ones[4], m_cnt[4];
  bit m_bits[4];
  int done_pulses;

  sng_frame4 #(.FRAME_LEN(FL), .CW(CW)) dut (
    .TRIG(TRIG), .RESET(RESET), .START(START),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3),
    .RND0(RND0), .RND1(RND1), .RND2(RND2), .RND3(RND3),
    .BIT0(BIT0), .BIT1(BIT1), .BIT2(BIT2), .BIT3(BIT3),
    .BUSY(BUSY), .DONE(DONE),
    .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
  );

  always #5 TRIG = ~TRIG;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int p[4];
    int r[4];
    p = '{int'(P0), int'(P1), int'(P2), int'(P3)};
    r = '{int'(RND0), int'(RND1), int'(RND2), int'(RND3)};
    if (RESET) begin
      m_run = 0; m_fin = 0; m_pos = 0;
      for (int i = 0; i < 4; i++) begin
        m_bits[i] = 0; m_cnt[i] = 0; m_ones[i] = 0; m_pl[i] = 0;
      end
    end else if (m_run) begin
      for (int i = 0; i < 4; i++) begin
        m_bits[i] = (r[i] < m_pl[i]);
        m_ones[i] += m_bits[i];
      end
      if (m_pos == FL - 1) begin
        m_run = 0; m_fin = 1;
        for (int i = 0; i < 4; i++) m_cnt[i] = m_ones[i];
      end else begin
        m_pos++;
      end
    end else begin
      m_fin = 0;
      for (int i = 0; i < 4; i++) m_bits[i] = 0;
      if (START) begin
        m_run = 1; m_pos = 0;
        for (int i = 0; i < 4; i++) begin
          m_pl[i] = p[i]; m_ones[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge TRIG);
    model_edge();
    #1;
    if (DONE) done_pulses++;
    check("busy", 32'(BUSY), 32'(m_run));
    check("done", 32'(DONE), 32'(m_fin));
    check("bits", {28'd0, BIT3, BIT2, BIT1, BIT0},
          {28'd0, m_bits[3], m_bits[2], m_bits[1], m_bits[0]});
    check("cnt0", 32'(CNT0), 32'(m_cnt[0]));
    check("cnt1", 32'(CNT1), 32'(m_cnt[1]));
    check("cnt2", 32'(CNT2), 32'(m_cnt[2]));
    check("cnt3", 32'(CNT3), 32'(m_cnt[3]));
  endtask

  task automatic set_rnd(input logic [3:0] v);
    RND0 = v; RND1 = v; RND2 = v; RND3 = v;
  endtask

  initial begin
    int lat;
    RESET = 1'b1; START = 1'b0;
    P0 = 0; P1 = 0; P2 = 0; P3 = 0;
    set_rnd(4'd0);
    step(); step();
    check("rst_cnt", {12'd0, CNT3, CNT2, CNT1, CNT0}, 32'd0);
    RESET = 1'b0;
    step();

    // Exhaustive compare: counter RND from e1, P = {0,5,10,15}.
    P0 = 0; P1 = 5; P2 = 10; P3 = 15;
    START = 1'b1;
    step();
    START = 1'b0;
    lat = 1;
    for (int k = 0; k < 40 && !DONE; k++) begin
      set_rnd(4'(k));
      step();
      if (!DONE) lat++;
    end
    check("latency", 32'(lat + 1), 32'd17);
    check("x_cnt", {12'd0, CNT3, CNT2, CNT1, CNT0}, {12'd0, 5'd15, 5'd10, 5'd5, 5'd0});
    step();

    // Mid-frame P change and START re-assertion are ignored.
    done_pulses = 0;
    P0 = 8; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_rnd(4'(k));
      if (k == 4) P0 = 3;
      START = (k == 6);
      step();
    end
    START = 1'b0;
    check("mid_cnt0", 32'(CNT0), 32'd8);
    check("mid_pulses", 32'(done_pulses), 32'd1);

    // Reset mid-frame aborts with no DONE pulse.
    P0 = 9; P1 = 2; P2 = 7; P3 = 12;
    START = 1'b1; step(); START = 1'b0;
    for (int k = 0; k < 8; k++) begin set_rnd(4'($urandom)); step(); end
    RESET = 1'b1; step(); RESET = 1'b0;
    check("abort_all", {12'd0, CNT3, CNT2, CNT1, CNT0, BIT3, BIT2, BIT1, BIT0, BUSY, DONE}, 32'd0);
    done_pulses = 0;
    for (int k = 0; k < 20; k++) step();
    check("abort_pulses", 32'(done_pulses), 32'd0);

    // Back-to-back frames with START held high.
    P0 = 15; done_pulses = 0; START = 1'b1;
    for (int k = 0; k < 51; k++) begin
      set_rnd(4'(k));
      step();
    end
    START = 1'b0;
    check("b2b_pulses", 32'(done_pulses), 32'd3);
    check("b2b_cnt0", 32'(CNT0), 32'd15);
    for (int k = 0; k < 20; k++) step();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      RESET = ($urandom_range(0, 199) == 0);
      START = ($urandom_range(0, 3) == 0);
      P0 = 4'($urandom); P1 = 4'($urandom); P2 = 4'($urandom); P3 = 4'($urandom);
      RND0 = 4'($urandom); RND1 = 4'($urandom); RND2 = 4'($urandom); RND3 = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
